// File: rtl/dawson32_op_feeder.sv
// Operand FIFO and single-outstanding issue sequencer feeding dawson32_if.
// Buffers operand pairs, issues one at a time, holds each result in a valid/ready register.
module dawson32_op_feeder #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [31:0]   in_a,
    input  logic [31:0]   in_b,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [31:0]   a,
    output logic [31:0]   b,
    output logic          ready_in,
    input  logic [31:0]   out,
    input  logic          ready_out,
    output logic [31:0]   res,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [CW-1:0] count,
    output logic          busy
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } state_e;

    state_e         state;
    logic [63:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [63:0]    head;
    logic           full;
    logic           push;
    logic           pop;

    assign full     = (count == CW'(DEPTH));
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    // Issue only when the result slot is free or being freed this edge.
    assign pop      = (state == StIdle) && (count != '0) && (!res_valid || res_ready);
    assign head     = mem[rd_ptr];
    assign busy     = (state != StIdle);

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {in_a, in_b};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= StIdle;
            a         <= '0;
            b         <= '0;
            ready_in  <= 1'b0;
            res       <= '0;
            res_valid <= 1'b0;
        end else begin
            if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
            case (state)
                StIdle: begin
                    if (pop) begin
                        a        <= head[63:32];
                        b        <= head[31:0];
                        ready_in <= 1'b1;
                        state    <= StReq;
                    end
                end
                StReq: begin
                    ready_in <= 1'b0;
                    state    <= StWait;
                end
                StWait: begin
                    if (ready_out) begin
                        res       <= out;
                        res_valid <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dawson32_op_feeder.sv
// Directed self-checking bench for dawson32_op_feeder with a behavioural dawson32_if model.
module tb_dawson32_op_feeder;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] in_a, in_b;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        ready_in;
    logic [31:0] out;
    logic        ready_out;
    logic [31:0] res;
    logic        res_valid;
    logic        res_ready;
    logic [2:0]  count;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    // Interface model: result pulse 6 cycles after sampling ready_in, out = a + b.
    logic        model_ro  = 1'b0;
    logic [31:0] model_out = '0;
    logic        pend      = 1'b0;
    int          dly       = 0;
    logic [31:0] val       = '0;
    int          model_pulses = 0;
    logic        spur_ro   = 1'b0;
    logic [31:0] spur_out  = '0;

    logic [31:0] got[$];
    int          issues = 0;

    assign ready_out = model_ro | spur_ro;
    assign out       = spur_ro ? spur_out : model_out;

    always #5 clock = ~clock;

    dawson32_op_feeder #(.DEPTH(4)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ready_in  (ready_in),
        .out       (out),
        .ready_out (ready_out),
        .res       (res),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .count     (count),
        .busy      (busy)
    );

    always @(posedge clock) begin
        model_ro <= 1'b0;
        if (ready_in) begin
            pend <= 1'b1;
            dly  <= 5;
            val  <= a + b;
        end else if (pend) begin
            if (dly == 0) begin
                model_ro     <= 1'b1;
                model_out    <= val;
                pend         <= 1'b0;
                model_pulses <= model_pulses + 1;
            end else begin
                dly <= dly - 1;
            end
        end
    end

    always @(negedge clock) begin
        if (res_valid && res_ready) got.push_back(res);
        if (ready_in) issues++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] pa, input logic [31:0] pb);
        int k = 0;
        in_a = pa;
        in_b = pb;
        in_valid = 1'b1;
        @(negedge clock);
        while (!in_ready && k < 100) begin
            @(negedge clock);
            k++;
        end
        check_val("push_accept", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_got(input int n, input string tag);
        int k = 0;
        while (got.size() < n && k < 200) begin
            @(negedge clock);
            k++;
        end
        check_val(tag, 32'(got.size()), 32'(n));
    endtask

    initial begin
        int iss0;
        int pulses0;
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_a      = 32'd55;
        in_b      = 32'd66;
        res_ready = 1'b0;

        // Reset with in_valid held high
        repeat (2) @(posedge clock);
        #1 in_valid = 1'b0;
        reset_n = 1'b1;
        @(negedge clock);
        check_val("rst_count", 32'(count), 32'd0);
        check_val("rst_res_valid", 32'(res_valid), 32'd0);
        check_val("rst_ready_in", 32'(ready_in), 32'd0);
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_a", a, 32'd0);
        check_val("rst_b", b, 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_res", res, 32'd0);

        // Single operation with exact push-to-issue timing
        @(posedge clock);
        #1 res_ready = 1'b1;
        in_a = 32'd1;
        in_b = 32'd2;
        in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        @(negedge clock);
        check_val("single_count_after_push", 32'(count), 32'd1);
        check_val("single_no_issue_yet", 32'(ready_in), 32'd0);
        @(negedge clock);
        check_val("single_ready_in", 32'(ready_in), 32'd1);
        check_val("single_a", a, 32'd1);
        check_val("single_b", b, 32'd2);
        check_val("single_count_popped", 32'(count), 32'd0);
        check_val("single_busy", 32'(busy), 32'd1);
        @(negedge clock);
        check_val("single_pulse_one_cycle", 32'(ready_in), 32'd0);
        wait_got(1, "single_result_count");
        check_val("single_res", got[0], 32'd3);
        check_val("single_issues", 32'(issues), 32'd1);
        check_val("single_count_end", 32'(count), 32'd0);

        // Fill and order with stalled consumer
        got.delete();
        @(posedge clock);
        #1 res_ready = 1'b0;
        iss0 = issues;
        for (int i = 0; i < 5; i++) push(32'(10 + i), 32'd1);
        repeat (20) @(negedge clock);
        check_val("fill_count", 32'(count), 32'd4);
        check_val("fill_in_ready", 32'(in_ready), 32'd0);
        check_val("fill_res_valid", 32'(res_valid), 32'd1);
        check_val("fill_res_first", res, 32'd11);
        check_val("fill_one_issue", 32'(issues - iss0), 32'd1);
        check_val("fill_idle", 32'(busy), 32'd0);
        @(posedge clock);
        #1 res_ready = 1'b1;
        wait_got(5, "fill_result_count");
        for (int i = 0; i < 5; i++) check_val("fill_order", got[i], 32'(11 + i));
        check_val("fill_count_end", 32'(count), 32'd0);

        // Push rejected while full; pop frees one slot; wrapped order preserved
        got.delete();
        @(posedge clock);
        #1 res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(32'(20 + i), 32'd1);
        repeat (15) @(negedge clock);
        check_val("full_res", res, 32'd21);
        check_val("full_count", 32'(count), 32'd4);
        @(posedge clock);
        #1 in_a = 32'd25;
        in_b = 32'd1;
        in_valid = 1'b1;
        @(negedge clock);
        check_val("full_reject_in_ready", 32'(in_ready), 32'd0);
        @(posedge clock);
        #1 res_ready = 1'b1;
        @(negedge clock);
        check_val("full_reject_count", 32'(count), 32'd4);
        @(posedge clock);
        @(negedge clock);
        check_val("full_pop_count", 32'(count), 32'd3);
        check_val("full_pop_in_ready", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1 in_valid = 1'b0;
        @(negedge clock);
        check_val("full_refill_count", 32'(count), 32'd4);
        wait_got(6, "full_result_count");
        for (int i = 0; i < 6; i++) check_val("wrap_order", got[i], 32'(21 + i));

        // Spurious ready_out in IDLE and in REQ
        got.delete();
        @(posedge clock);
        #1 spur_ro = 1'b1;
        spur_out = 32'd99;
        @(posedge clock);
        #1 spur_ro = 1'b0;
        @(negedge clock);
        check_val("spur_idle_res_valid", 32'(res_valid), 32'd0);
        check_val("spur_idle_res", res, 32'd26);
        check_val("spur_idle_busy", 32'(busy), 32'd0);
        in_a = 32'd3;
        in_b = 32'd4;
        in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        @(posedge clock);
        #1 spur_ro = 1'b1;
        @(negedge clock);
        check_val("spur_req_state", 32'(ready_in), 32'd1);
        @(posedge clock);
        #1 spur_ro = 1'b0;
        @(negedge clock);
        check_val("spur_req_res_valid", 32'(res_valid), 32'd0);
        check_val("spur_req_busy", 32'(busy), 32'd1);
        wait_got(1, "spur_result_count");
        check_val("spur_req_res", got[0], 32'd7);

        // Reset in WAIT; late model pulse must be ignored
        got.delete();
        repeat (2) @(posedge clock);
        pulses0 = model_pulses;
        push(32'd5, 32'd6);
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (10) @(negedge clock);
        check_val("rstmid_late_pulse_seen", 32'(model_pulses - pulses0), 32'd1);
        check_val("rstmid_no_result", 32'(got.size()), 32'd0);
        check_val("rstmid_res_valid", 32'(res_valid), 32'd0);
        check_val("rstmid_busy", 32'(busy), 32'd0);
        @(posedge clock);
        #1;
        push(32'd7, 32'd8);
        wait_got(1, "rstmid_result_count");
        check_val("rstmid_new_res", got[0], 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dawson32_op_feeder.md
# dawson32_op_feeder

Operand queue and issue sequencer that sits directly upstream of `dawson32_if`. It buffers operand pairs from a valid/ready producer and issues them one at a time to the interface's `a`/`b`/`ready_in` user port. It captures each `out` on the interface's one-cycle `ready_out` pulse and presents it to a consumer through a single-entry valid/ready result register.

## Interface
- `DEPTH`, default 4: operand FIFO entries; must be a power of two and at least 2.
- `CW`, default `$clog2(DEPTH)+1`: width of the `count` output.

Ports:
- `clock`  in  1  single clock; all logic is on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `in_a`  in  32  operand A from the producer.
- `in_b`  in  32  operand B from the producer.
- `in_valid`  in  1  producer has a pair.
- `in_ready`  out  1  FIFO can accept a pair; equals FIFO not full.
- `a`  out  32  operand A to `dawson32_if`; registered.
- `b`  out  32  operand B to `dawson32_if`; registered.
- `ready_in`  out  1  one-cycle issue pulse to `dawson32_if`; registered.
- `out`  in  32  result from `dawson32_if`.
- `ready_out`  in  1  result-valid pulse from `dawson32_if`; lasts one cycle.
- `res`  out  32  held result.
- `res_valid`  out  1  `res` holds an unconsumed result.
- `res_ready`  in  1  consumer takes `res`.
- `count`  out  CW  FIFO occupancy, 0 to DEPTH.
- `busy`  out  1  FSM is not in IDLE.

## Operation
- **Reset** (`reset_n`=0 at an edge):
  - FSM goes to IDLE; FIFO is emptied (pointers and count to 0).
  - Outputs: `a`=0, `b`=0, `ready_in`=0, `res`=0, `res_valid`=0, `busy`=0, `count`=0, `in_ready`=1.
  - Reset mid-operation abandons any in-flight operation. A `ready_out` arriving later is ignored, because the FSM is no longer in WAIT.
- **Push:** occurs when `in_valid && in_ready`; `{in_a,in_b}` is written at the write pointer.
  - When full, `in_ready`=0. There is no pass-through, even if a pop happens in the same cycle.
- **Pop:** occurs only on the IDLE→REQ transition.
- **Simultaneous push and pop:** `count` is unchanged and both pointers advance.
- **Wrap-around:** pointers are `$clog2(DEPTH)` bits and wrap naturally.
- **FSM states:**
  - IDLE:
    - Leave when `count`≠0 and (`!res_valid` or `res_ready`).
    - At that edge: load `a`/`b` from the FIFO head, pop, set `ready_in`←1, go to REQ.
  - REQ: `ready_in`←0, go to WAIT unconditionally. `ready_in` is high for exactly one cycle.
  - WAIT: on `ready_out`=1, set `res`←`out`, `res_valid`←1, go to IDLE.
- **Operand stability:** `a` and `b` are held stable from REQ until the edge that leaves WAIT.
- **Spurious `ready_out`:** `ready_out` outside WAIT is ignored; there is no state or result change.
- **Result register:**
  - `res_valid` clears on `res_ready && res_valid` unless a new capture happens at the same edge.
  - A same-edge capture cannot occur, because issue requires the slot to be free or freeing. A new result therefore never overwrites an unconsumed one.
- **Status:** `busy` = (state≠IDLE). Only one operation is ever outstanding at `dawson32_if`.

## Timing
- **Push to issue pulse:** pair pushed at edge E0; FSM leaves IDLE at E1; `ready_in`=1 during cycle E1–E2. `dawson32_if` samples it at E2.
  - Minimum push-to-`ready_in` latency is therefore 1 cycle after acceptance.
- **Result capture:** `ready_out` sampled high at edge Er makes `res_valid`=1 from Er. The earliest next `ready_in` rises at Er+1.
- **Back-to-back issue:** back-to-back pairs are issued with at least 3 cycles between `ready_in` pulses (REQ, WAIT≥1, IDLE), plus the interface latency.
- **Consumer stall:** while `res_valid`=1 and `res_ready`=0, the FSM stays in IDLE and the FIFO keeps filling to DEPTH.

## Test plan
Bench model of `dawson32_if`: on sampling `ready_in`, it raises `ready_out` for one cycle 6 cycles later with `out`=`a`+`b`.
- **Reset:** hold `reset_n`=0 for 2 cycles with `in_valid`=1 → after release `count`=0, `res_valid`=0, `ready_in`=0, `in_ready`=1, `a`=`b`=0.
- **Single operation:** push (1,2) with `res_ready`=1 → `ready_in` pulses once with `a`=1, `b`=2; `res`=3 with `res_valid`=1; `count` returns to 0.
- **Fill and order:** push 5 pairs (10,1)…(14,1) with `res_ready`=0 →
  - the first is issued; `count` reaches 4 and `in_ready`=0;
  - after raising `res_ready`, results arrive in order 11,12,13,14,15;
  - no result is overwritten.
- **Simultaneous push/pop at full:** at DEPTH=4, a push is rejected while full; in the pop cycle `count` goes 4→3, then a push is accepted. Pointer wrap preserves order.
- **Spurious `ready_out`:**
  - pulse `ready_out` with `out`=99 in IDLE → no `res_valid`;
  - pulse it during REQ → ignored, and the correct result is still captured in WAIT.
- **Reset mid-operation:** assert reset in WAIT, then let the model's late `ready_out` arrive → `res_valid` stays 0, `busy`=0; a new push (7,8) yields `res`=15.
